// File: rtl/lsu_pipelined.sv
// rtl/lsu_pipelined.sv - pipelined RV32I load/store unit with DMEM and memory-mapped IO
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_lsu_req / o_lsu_ready   request handshake, accepted when both high at a clock edge
//   i_lsu_addr, i_st_data     byte address and right-aligned store data
//   i_lsu_size                00 byte, 01 half, 10 word, 11 illegal
//   i_lsu_unsigned            zero-extend byte/half loads
//   i_lsu_wren                1 = store, 0 = load
//   o_ld_data                 extended load data, valid with o_lsu_done on a load
//   o_lsu_done / o_lsu_fault  completion pulse and its not-performed qualifier
//   o_io_ledr, o_io_ledg, o_io_hex, o_io_lcd   IO output registers
//   i_io_sw                   asynchronous switch inputs
module lsu_pipelined #(
    parameter int DMEM_WORDS     = 2048,
    parameter int NUM_HEX        = 8,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_lsu_req,
    output logic                      o_lsu_ready,
    input  logic [31:0]               i_lsu_addr,
    input  logic [31:0]               i_st_data,
    input  logic [1:0]                i_lsu_size,
    input  logic                      i_lsu_unsigned,
    input  logic                      i_lsu_wren,
    output logic [31:0]               o_ld_data,
    output logic                      o_lsu_done,
    output logic                      o_lsu_fault,
    output logic [31:0]               o_io_ledr,
    output logic [31:0]               o_io_ledg,
    output logic [NUM_HEX-1:0][6:0]   o_io_hex,
    output logic [31:0]               o_io_lcd,
    input  logic [31:0]               i_io_sw
);
    localparam int AW = $clog2(DMEM_WORDS);

    localparam logic [29:0] WA_LEDR = 30'h0400_0000;
    localparam logic [29:0] WA_LEDG = 30'h0400_0400;
    localparam logic [29:0] WA_HEX0 = 30'h0400_0800;
    localparam logic [29:0] WA_HEX1 = 30'h0400_0C00;
    localparam logic [29:0] WA_LCD  = 30'h0400_1000;
    localparam logic [29:0] WA_SW   = 30'h0400_4000;

    typedef enum logic [1:0] {S_IDLE, S_SECOND, S_RESP} state_t;

    state_t                     state_q;
    logic                       done_q, fault_q, wren_q, uns_q;
    logic [1:0]                 size_q, off_q;
    logic [31:0]                ledr_q, ledg_q, lcd_q, sw_s1_q, sw_s2_q;
    logic [NUM_HEX-1:0][6:0]    hex_q;
    logic [31:0]                mem [DMEM_WORDS];
    logic [31:0]                lo_q, hi_q, hi_wd_q;
    logic [3:0]                 hi_be_q;
    logic [AW-1:0]              hi_idx_q;

    // Request decode
    logic [3:0]    size_be;
    logic [7:0]    be64;
    logic [63:0]   wd64;
    logic [29:0]   word_addr;
    logic [AW-1:0] word_idx;
    logic          crosses, is_dmem, is_io, accept, fault_c, split_c;
    logic          sel_ledr, sel_ledg, sel_hex0, sel_hex1, sel_lcd, sel_sw;
    logic [63:0]   hex_rd;
    logic [31:0]   io_rd, raw, ext;

    always_comb begin
        size_be = 4'b0000;
        case (i_lsu_size)
            2'b00:   size_be = 4'b0001;
            2'b01:   size_be = 4'b0011;
            2'b10:   size_be = 4'b1111;
            default: size_be = 4'b0000;
        endcase
    end

    // Lanes and data laid out across a two-word window; the upper half is the second beat.
    assign be64      = {4'b0000, size_be} << i_lsu_addr[1:0];
    assign wd64      = {32'h0, i_st_data} << {i_lsu_addr[1:0], 3'b000};
    assign crosses   = |be64[7:4];
    assign word_addr = i_lsu_addr[31:2];
    assign word_idx  = i_lsu_addr[AW+1:2];
    assign is_dmem   = (i_lsu_addr[31:AW+2] == '0);
    assign sel_ledr  = (word_addr == WA_LEDR);
    assign sel_ledg  = (word_addr == WA_LEDG);
    assign sel_hex0  = (word_addr == WA_HEX0);
    assign sel_hex1  = (word_addr == WA_HEX1);
    assign sel_lcd   = (word_addr == WA_LCD);
    assign sel_sw    = (word_addr == WA_SW);
    assign is_io     = sel_ledr | sel_ledg | sel_hex0 | sel_hex1 | sel_lcd | sel_sw;

    // A crossing access in the last DMEM word would need word+1, which does not exist.
    assign fault_c = (i_lsu_size == 2'b11) || !(is_dmem || is_io)
                   || (crosses && (is_io || (MISALIGN_SPLIT == 0) || (&word_idx)))
                   || (i_lsu_wren && sel_sw);
    assign split_c = crosses && !fault_c;

    assign o_lsu_ready = (state_q != S_SECOND);
    assign accept      = i_lsu_req && o_lsu_ready && i_reset;

    always_comb begin
        hex_rd = '0;
        for (int d = 0; d < NUM_HEX; d++) hex_rd[8*d +: 7] = hex_q[d];
    end

    always_comb begin
        io_rd = '0;
        if (sel_ledr)      io_rd = ledr_q;
        else if (sel_ledg) io_rd = ledg_q;
        else if (sel_hex0) io_rd = hex_rd[31:0];
        else if (sel_hex1) io_rd = hex_rd[63:32];
        else if (sel_lcd)  io_rd = lcd_q;
        else if (sel_sw)   io_rd = sw_s2_q;
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            wren_q  <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            ledr_q  <= '0;
            ledg_q  <= '0;
            lcd_q   <= '0;
            hex_q   <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= i_io_sw;
            sw_s2_q <= sw_s1_q;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            if (state_q == S_SECOND) begin
                state_q <= S_RESP;
                done_q  <= 1'b1;
            end else if (accept) begin
                wren_q <= i_lsu_wren;
                uns_q  <= i_lsu_unsigned;
                size_q <= i_lsu_size;
                off_q  <= i_lsu_addr[1:0];
                if (split_c) begin
                    state_q <= S_SECOND;
                end else begin
                    state_q <= S_RESP;
                    done_q  <= 1'b1;
                    fault_q <= fault_c;
                end
                if (!fault_c && i_lsu_wren) begin
                    if (sel_ledr) ledr_q <= merge(ledr_q, wd64[31:0], be64[3:0]);
                    if (sel_ledg) ledg_q <= merge(ledg_q, wd64[31:0], be64[3:0]);
                    if (sel_lcd)  lcd_q  <= merge(lcd_q, wd64[31:0], be64[3:0]);
                    for (int d = 0; d < NUM_HEX; d++) begin
                        if (((d < 4) ? sel_hex0 : sel_hex1) && be64[d%4])
                            hex_q[d] <= wd64[8*(d%4) +: 7];
                    end
                end
            end else begin
                state_q <= S_IDLE;
            end
        end
    end

    // Data memory and beat buffers; intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (accept && !fault_c) begin
            if (is_dmem) begin
                if (i_lsu_wren) begin
                    for (int b = 0; b < 4; b++)
                        if (be64[b]) mem[word_idx][8*b +: 8] <= wd64[8*b +: 8];
                end else begin
                    lo_q <= mem[word_idx];
                end
            end else begin
                lo_q <= io_rd;
            end
            hi_idx_q <= word_idx + AW'(1);
            hi_be_q  <= be64[7:4];
            hi_wd_q  <= wd64[63:32];
        end
        if (state_q == S_SECOND && i_reset) begin
            if (wren_q) begin
                for (int b = 0; b < 4; b++)
                    if (hi_be_q[b]) mem[hi_idx_q][8*b +: 8] <= hi_wd_q[8*b +: 8];
            end else begin
                hi_q <= mem[hi_idx_q];
            end
        end
    end

    // Split loads align the held first word with the second; single loads only use lo_q lanes.
    assign raw = 32'({hi_q, lo_q} >> {off_q, 3'b000});

    always_comb begin
        ext = raw;
        case (size_q)
            2'b00:   ext = {{24{~uns_q & raw[7]}}, raw[7:0]};
            2'b01:   ext = {{16{~uns_q & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    assign o_ld_data   = (done_q && !fault_q && !wren_q) ? ext : 32'h0;
    assign o_lsu_done  = done_q;
    assign o_lsu_fault = fault_q;
    assign o_io_ledr   = ledr_q;
    assign o_io_ledg   = ledg_q;
    assign o_io_lcd    = lcd_q;
    assign o_io_hex    = hex_q;
endmodule

// File: tb/tb_lsu_pipelined.sv
// tb/tb_lsu_pipelined.sv - scoreboard bench for lsu_pipelined (split and fault builds)
module tb_lsu_pipelined;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [31:0] addr = '0, sdata = '0, sw_in = '0;
    logic [1:0]  size = 2'b10;
    logic        uns = 1'b0, wren = 1'b0;

    logic        ready_a, done_a, fault_a, ready_b, done_b, fault_b;
    logic [31:0] ld_a, ledr_a, ledg_a, lcd_a, ld_b, ledr_b, ledg_b, lcd_b;
    logic [7:0][6:0] hex_a, hex_b;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;
    exp_t sb[$];
    logic [31:0] wdata [10];

    always #5 clk = ~clk;

    lsu_pipelined #(.DMEM_WORDS(2048), .NUM_HEX(8), .MISALIGN_SPLIT(1)) dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_lsu_req(req_a), .o_lsu_ready(ready_a),
        .i_lsu_addr(addr), .i_st_data(sdata), .i_lsu_size(size), .i_lsu_unsigned(uns),
        .i_lsu_wren(wren), .o_ld_data(ld_a), .o_lsu_done(done_a), .o_lsu_fault(fault_a),
        .o_io_ledr(ledr_a), .o_io_ledg(ledg_a), .o_io_hex(hex_a), .o_io_lcd(lcd_a),
        .i_io_sw(sw_in));

    lsu_pipelined #(.DMEM_WORDS(64), .NUM_HEX(8), .MISALIGN_SPLIT(0)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_lsu_req(req_b), .o_lsu_ready(ready_b),
        .i_lsu_addr(addr), .i_st_data(sdata), .i_lsu_size(size), .i_lsu_unsigned(uns),
        .i_lsu_wren(wren), .o_ld_data(ld_b), .o_lsu_done(done_b), .o_lsu_fault(fault_b),
        .o_io_ledr(ledr_b), .o_io_ledg(ledg_b), .o_io_hex(hex_b), .o_io_lcd(lcd_b),
        .i_io_sw(sw_in));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the completing response.
    task automatic check_resp(input int which, input string tag);
        exp_t e;
        check({tag, "_done"}, 32'((which == 0) ? done_a : done_b), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, (which == 0) ? ld_a : ld_b, e.data);
            check({tag, "_fault"}, 32'((which == 0) ? fault_a : fault_b), 32'(e.fault));
        end
    endtask

    task automatic access(input int which, input string tag, input logic w, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input logic exp_f, input logic split);
        @(negedge clk);
        wren = w; size = sz; uns = u; addr = a; sdata = d;
        if (which == 0) req_a = 1'b1; else req_b = 1'b1;
        sb.push_back('{exp_d, exp_f});
        check({tag, "_ready"}, 32'((which == 0) ? ready_a : ready_b), 32'd1);
        @(negedge clk);
        req_a = 1'b0; req_b = 1'b0;
        if (split) begin
            check({tag, "_ready_second"}, 32'(ready_a), 32'd0);
            check({tag, "_done_early"}, 32'(done_a), 32'd0);
            @(negedge clk);
        end
        check_resp(which, tag);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_fault", 32'(fault_a), 32'd0);
        check("rst_ld", ld_a, 32'h0);
        check("rst_ledr", ledr_a, 32'h0);
        check("rst_hex", 32'(hex_a[0]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", 32'(ready_a), 32'd1);

        // Word stores, then back-to-back loads at one per cycle
        for (int i = 0; i < 10; i++) begin
            wdata[i] = $urandom;
            access(0, "sw_loop", 1'b1, 2'b10, 1'b0, 32'(4 * i), wdata[i], 32'h0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0) check_resp(0, "lw_b2b");
            wren = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'(4 * i); req_a = 1'b1;
            check("lw_b2b_ready", 32'(ready_a), 32'd1);
            sb.push_back('{wdata[i], 1'b0});
        end
        @(negedge clk);
        req_a = 1'b0;
        check_resp(0, "lw_b2b_last");

        // Byte lanes and extension
        access(0, "sw100", 1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0, 1'b0, 1'b0);
        access(0, "sb101", 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 32'h0, 1'b0, 1'b0);
        access(0, "lw100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h1122A544, 1'b0, 1'b0);
        access(0, "lb101", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'hFFFFFFA5, 1'b0, 1'b0);
        access(0, "lbu101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 32'h000000A5, 1'b0, 1'b0);
        access(0, "lh102", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h00001122, 1'b0, 1'b0);
        access(0, "lh101", 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h000022A5, 1'b0, 1'b0);
        access(0, "lh100s", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h0000A544 | 32'hFFFF0000, 1'b0, 1'b0);

        // Split store/load
        access(0, "z200", 1'b1, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0);
        access(0, "z204", 1'b1, 2'b10, 1'b0, 32'h204, 32'h0, 32'h0, 1'b0, 1'b0);
        access(0, "sw203", 1'b1, 2'b10, 1'b0, 32'h203, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        access(0, "lw200", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'hEF000000, 1'b0, 1'b0);
        access(0, "lw204", 1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h00DEADBE, 1'b0, 1'b0);
        access(0, "lw203", 1'b0, 2'b10, 1'b0, 32'h203, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        access(0, "lh203", 1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 32'hFFFFBEEF, 1'b0, 1'b1);

        // IO
        access(0, "sw_ledr", 1'b1, 2'b10, 1'b0, 32'h1000_0000, 32'h0003FFFF, 32'h0, 1'b0, 1'b0);
        check("ledr", ledr_a, 32'h0003FFFF);
        access(0, "sw_hex0", 1'b1, 2'b10, 1'b0, 32'h1000_2000, 32'h40794024, 32'h0, 1'b0, 1'b0);
        check("hex0", 32'(hex_a[0]), 32'h24);
        check("hex1", 32'(hex_a[1]), 32'h40);
        check("hex2", 32'(hex_a[2]), 32'h79);
        check("hex3", 32'(hex_a[3]), 32'h40);
        access(0, "sw_hex1", 1'b1, 2'b10, 1'b0, 32'h1000_3000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
        access(0, "lw_hex1", 1'b0, 2'b10, 1'b0, 32'h1000_3000, 32'h0, 32'h7F7F7F7F, 1'b0, 1'b0);
        access(0, "sb_lcd", 1'b1, 2'b00, 1'b0, 32'h1000_4002, 32'h0000005A, 32'h0, 1'b0, 1'b0);
        check("lcd", lcd_a, 32'h005A0000);
        @(negedge clk);
        sw_in = 32'hDEADBEEF;
        @(negedge clk);
        access(0, "lw_sw", 1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Faults
        access(0, "unmapped", 1'b0, 2'b10, 1'b0, 32'h3000_0000, 32'h0, 32'h0, 1'b1, 1'b0);
        access(0, "size11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0);
        access(0, "st_sw", 1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'h1, 32'h0, 1'b1, 1'b0);
        access(0, "io_cross", 1'b1, 2'b01, 1'b0, 32'h1000_0003, 32'hFFFF, 32'h0, 1'b1, 1'b0);
        check("ledr_kept", ledr_a, 32'h0003FFFF);
        access(0, "zlast", 1'b1, 2'b10, 1'b0, 32'h1FFC, 32'h0, 32'h0, 1'b0, 1'b0);
        access(0, "sw_edge", 1'b1, 2'b10, 1'b0, 32'h1FFE, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        access(0, "lw_last", 1'b0, 2'b10, 1'b0, 32'h1FFC, 32'h0, 32'h0, 1'b0, 1'b0);

        // Fault build: crossing store is refused and memory is untouched
        access(1, "b_sw0", 1'b1, 2'b10, 1'b0, 32'h0, 32'h01020304, 32'h0, 1'b0, 1'b0);
        access(1, "b_sw4", 1'b1, 2'b10, 1'b0, 32'h4, 32'h05060708, 32'h0, 1'b0, 1'b0);
        access(1, "b_sw3", 1'b1, 2'b10, 1'b0, 32'h3, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        access(1, "b_lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h01020304, 1'b0, 1'b0);
        access(1, "b_lw4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h05060708, 1'b0, 1'b0);

        // Reset in the middle of a split store
        access(0, "z300", 1'b1, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0);
        access(0, "z304", 1'b1, 2'b10, 1'b0, 32'h304, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        wren = 1'b1; size = 2'b10; addr = 32'h303; sdata = 32'hCAFEF00D; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        check("mid_ready_second", 32'(ready_a), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_done", 32'(done_a), 32'd0);
        check("mid_fault", 32'(fault_a), 32'd0);
        check("mid_ld", ld_a, 32'h0);
        check("mid_ledr", ledr_a, 32'h0);
        check("mid_hex", 32'(hex_a[2]), 32'h0);
        check("mid_lcd", lcd_a, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("mid_no_done", 32'(done_a), 32'd0);
        end
        rst_n = 1'b1;
        check("mid_ready_after", 32'(ready_a), 32'd1);
        access(0, "lw300", 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h0D000000, 1'b0, 1'b0);
        access(0, "lw304", 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 32'h00000000, 1'b0, 1'b0);

        @(negedge clk);
        check("no_stray_done", 32'(done_a), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
